// File: rtl/rr_parity_demux_if.sv
// rtl/rr_parity_demux_if.sv - upstream and per-channel downstream handshake bundle for rr_parity_demux
interface rr_parity_demux_if #(
   parameter int N_OUT = 4,
   parameter int WIDTH = 8
);
   localparam int SW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

   logic                   up_valid;
   logic                   up_ready;
   logic [WIDTH-1:0]       up_data;
   logic [N_OUT-1:0]       down_valid;
   logic [N_OUT-1:0]       down_ready;
   logic [N_OUT*WIDTH-1:0] down_data;
   logic [N_OUT-1:0]       down_parity;
   logic [SW-1:0]          cur_sel;

   modport master (
      output up_valid, up_data, down_ready,
      input  up_ready, down_valid, down_data, down_parity, cur_sel
   );

   modport slave (
      input  up_valid, up_data, down_ready,
      output up_ready, down_valid, down_data, down_parity, cur_sel
   );
endinterface

// File: rtl/rr_parity_demux.sv
// rtl/rr_parity_demux.sv - round-robin demux of one word stream into N_OUT one-entry slots with parity
module rr_parity_demux #(
   parameter int N_OUT = 4,
   parameter int WIDTH = 8
) (
   input logic              clk,
   input logic              rst,
   rr_parity_demux_if.slave bus
);
   localparam int SW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

   logic [N_OUT-1:0] valid_q;
   logic [WIDTH-1:0] data_q [N_OUT];
   logic [N_OUT-1:0] par_q;
   logic [SW-1:0]    sel_q;
   logic             ready_c;
   logic             xfer;

   // A full target slot may still accept when it is being drained in the same cycle.
   assign ready_c = !rst && (!valid_q[sel_q] || bus.down_ready[sel_q]);
   assign xfer    = bus.up_valid && ready_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         par_q   <= '0;
         sel_q   <= '0;
         for (int i = 0; i < N_OUT; i++) begin
            data_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_OUT; i++) begin
            if (valid_q[i] && bus.down_ready[i]) begin
               valid_q[i] <= 1'b0;
            end
         end
         if (xfer) begin
            valid_q[sel_q] <= 1'b1;
            data_q[sel_q]  <= bus.up_data;
            par_q[sel_q]   <= ^bus.up_data;
            sel_q          <= (sel_q == SW'(N_OUT - 1)) ? '0 : sel_q + 1'b1;
         end
      end
   end

   assign bus.up_ready    = ready_c;
   assign bus.down_valid  = valid_q;
   assign bus.down_parity = par_q;
   assign bus.cur_sel     = sel_q;

   for (genvar g = 0; g < N_OUT; g++) begin : g_data
      assign bus.down_data[g*WIDTH +: WIDTH] = data_q[g];
   end
endmodule

// File: tb/tb_rr_parity_demux.sv
// tb/tb_rr_parity_demux.sv - queue-model scoreboard plus directed literal checks for rr_parity_demux
module tb_rr_parity_demux;
   localparam int N = 4;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   rr_parity_demux_if #(.N_OUT(N), .WIDTH(W)) bus ();
   rr_parity_demux_if #(.N_OUT(3), .WIDTH(4)) bus3 ();

   rr_parity_demux #(.N_OUT(N), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));
   rr_parity_demux #(.N_OUT(3), .WIDTH(4)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

   always #5 clk = ~clk;

   // Model: one FIFO per channel of words accepted but not yet consumed, and a wrap-around pointer.
   logic [W-1:0] q [N][$];
   int           ptr  = 0;
   bit           live = 1'b0;

   task automatic chk(input string name, input int ch, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s ch%0d: got %0h expected %0h at %0t", name, ch, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      bit acc;
      if (rst) begin
         for (int i = 0; i < N; i++) q[i].delete();
         ptr  = 0;
         live = 1'b1;
      end else if (live) begin
         acc = bus.up_valid && (q[ptr].size() == 0 || bus.down_ready[ptr]);
         for (int i = 0; i < N; i++) begin
            if (q[i].size() != 0 && bus.down_ready[i]) void'(q[i].pop_front());
         end
         if (acc) begin
            q[ptr].push_back(bus.up_data);
            ptr = (ptr + 1) % N;
         end
      end
   end

   always @(negedge clk) begin
      if (live) begin
         chk("up_ready", 0, 32'(bus.up_ready), 32'(!rst && (q[ptr].size() == 0 || bus.down_ready[ptr])));
         chk("cur_sel", 0, 32'(bus.cur_sel), 32'(ptr));
         for (int i = 0; i < N; i++) begin
            chk("down_valid", i, 32'(bus.down_valid[i]), 32'(q[i].size() != 0));
            if (q[i].size() != 0) begin
               chk("down_data", i, 32'(bus.down_data[i*W +: W]), 32'(q[i][0]));
               chk("down_parity", i, 32'(bus.down_parity[i]), 32'(^q[i][0]));
            end
         end
      end
   end

   task automatic set_in(input logic v, input logic [W-1:0] d, input logic [N-1:0] r);
      bus.up_valid   = v;
      bus.up_data    = d;
      bus.down_ready = r;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [7:0] seq_d [5];
   logic       seq_p [5];

   initial begin
      seq_d = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h10};
      seq_p = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      bus3.up_valid   = 1'b0;
      bus3.up_data    = '0;
      bus3.down_ready = 3'b111;
      set_in(1'b0, 8'h00, 4'hF);
      tick();
      tick();
      chk("up_ready_in_rst", 0, 32'(bus.up_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("rst_valid", 0, 32'(bus.down_valid), 32'd0);
      chk("rst_data", 0, bus.down_data, 32'd0);
      chk("rst_parity", 0, 32'(bus.down_parity), 32'd0);
      chk("rst_sel", 0, 32'(bus.cur_sel), 32'd0);

      for (int k = 0; k < 5; k++) begin
         set_in(1'b1, seq_d[k], 4'hF);
         chk("seq_ready", k, 32'(bus.up_ready), 32'd1);
         tick();
         chk("seq_valid", k % N, 32'(bus.down_valid[k % N]), 32'd1);
         chk("seq_data", k % N, 32'(bus.down_data[(k % N)*W +: W]), 32'(seq_d[k]));
         chk("seq_parity", k % N, 32'(bus.down_parity[k % N]), 32'(seq_p[k]));
      end
      chk("seq_sel_end", 0, 32'(bus.cur_sel), 32'd1);

      rst = 1'b1;
      set_in(1'b0, 8'h00, 4'h0);
      tick();
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         set_in(1'b1, 8'(8'h20 + k), 4'h0);
         tick();
      end
      chk("full_valid", 0, 32'(bus.down_valid), 32'hF);
      chk("full_sel", 0, 32'(bus.cur_sel), 32'd0);
      chk("full_ready", 0, 32'(bus.up_ready), 32'd0);
      set_in(1'b1, 8'h24, 4'b0001);
      chk("drainload_ready", 0, 32'(bus.up_ready), 32'd1);
      tick();
      chk("drainload_valid", 0, 32'(bus.down_valid), 32'hF);
      chk("drainload_data", 0, 32'(bus.down_data[0 +: W]), 32'h24);
      chk("drainload_sel", 0, 32'(bus.cur_sel), 32'd1);

      set_in(1'b0, 8'h00, 4'hF);
      tick();
      set_in(1'b1, 8'h33, 4'hF);
      tick();
      set_in(1'b1, 8'hA5, 4'b1011);
      tick();
      set_in(1'b1, 8'h44, 4'b1011);
      tick();
      set_in(1'b1, 8'h55, 4'b1011);
      tick();
      set_in(1'b1, 8'h66, 4'b1011);
      tick();
      set_in(1'b1, 8'h5A, 4'b1011);
      for (int k = 0; k < 10; k++) begin
         chk("stall_ready", 2, 32'(bus.up_ready), 32'd0);
         chk("stall_data", 2, 32'(bus.down_data[2*W +: W]), 32'hA5);
         chk("stall_parity", 2, 32'(bus.down_parity[2]), 32'd0);
         tick();
      end
      set_in(1'b1, 8'h5A, 4'hF);
      chk("unstall_ready", 2, 32'(bus.up_ready), 32'd1);
      tick();
      chk("unstall_data", 2, 32'(bus.down_data[2*W +: W]), 32'h5A);
      chk("unstall_valid", 2, 32'(bus.down_valid[2]), 32'd1);

      set_in(1'b0, 8'h00, 4'hF);
      tick();
      for (int k = 0; k < 3; k++) begin
         set_in(1'b1, 8'(8'h71 + k), 4'h0);
         tick();
      end
      chk("pre_rst_valid", 0, 32'(bus.down_valid), 32'b1011);
      rst = 1'b1;
      set_in(1'b1, 8'h74, 4'h0);
      chk("mid_rst_ready", 0, 32'(bus.up_ready), 32'd0);
      tick();
      chk("mid_rst_valid", 0, 32'(bus.down_valid), 32'd0);
      chk("mid_rst_sel", 0, 32'(bus.cur_sel), 32'd0);
      rst = 1'b0;
      set_in(1'b1, 8'h77, 4'h0);
      tick();
      chk("post_rst_valid", 0, 32'(bus.down_valid), 32'b0001);
      chk("post_rst_data", 0, 32'(bus.down_data[0 +: W]), 32'h77);

      for (int c = 0; c < 10000; c++) begin
         logic [N-1:0] r;
         for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 9) < 7);
         set_in(1'($urandom_range(0, 1)), 8'($urandom), r);
         tick();
      end
      set_in(1'b0, 8'h00, 4'hF);
      tick();
      chk("final_empty", 0, 32'(bus.down_valid), 32'd0);

      chk("n3_sel_start", 0, 32'(bus3.cur_sel), 32'd0);
      for (int k = 0; k < 7; k++) begin
         bus3.up_valid = 1'b1;
         bus3.up_data  = 4'(k + 1);
         #1;
         chk("n3_ready", k, 32'(bus3.up_ready), 32'd1);
         tick();
         chk("n3_order", k % 3, 32'(bus3.down_valid), 32'(3'b001 << (k % 3)));
         chk("n3_data", k % 3, 32'(bus3.down_data[(k % 3)*4 +: 4]), 32'(k + 1));
      end
      bus3.up_valid = 1'b0;
      chk("n3_sel_end", 0, 32'(bus3.cur_sel), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
